vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-timing engine that consumes the pixel-rate enable from the clock-divider block.
- Generates hsync/vsync/data-enable for the VGA DAC.
- Pulls pixel words from the DDR3 read-side FIFO with a valid/ready handshake.
- Runs entirely on the system clock; pixel rate is set by the pix_en strobe, not a derived clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hs/vs (0 = active-low)
- DATA_W, 24, pixel word width (RGB888)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  single-cycle pixel strobe; counters advance only when high
- pix_data  in  DATA_W  pixel word from read FIFO
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  pixel consumed this cycle when pix_ready && pix_valid
- underflow_clr  in  1  clears sticky underflow flag
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  active-video enable
- vga_rgb  out  DATA_W  pixel output
- pos_x  out  11  column of the displayed pixel
- pos_y  out  10  line of the displayed pixel
- frame_start  out  1  one-clk pulse at the first pixel of each frame
- underflow  out  1  sticky: an active pixel was needed while pix_valid was low

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and increments only on pix_en.
  - On wrap to 0, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
- Region order per axis: active [0, ACTIVE), front porch, sync, back porch.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- pix_ready = pix_en && active. It is combinational from the current counters and has no dependency on pix_valid.
- Output registers load only on pix_en cycles and hold otherwise. Latency is 1 clk from the pix_en edge.
  - vga_hs = SYNC_POL when h_cnt is in the hsync region, else ~SYNC_POL. vga_vs follows the same rule on v_cnt.
  - vga_de = active; pos_x = h_cnt; pos_y = v_cnt.
  - vga_rgb = pix_data if active && pix_valid; 0 if active && !pix_valid; 0 when not active.
  - frame_start = 1 for exactly one clk, following the pix_en where h_cnt = 0 and v_cnt = 0. It is 0 on all other clks, including non-pix_en clks.
- Underflow flag:
  - Set on pix_en && active && !pix_valid.
  - Cleared by underflow_clr. If set and clear occur in the same cycle, set wins.
  - The FIFO word is not consumed when underflow occurs; timing continues unaffected.
- pix_valid high outside the active region: ignored; no pop.
- pix_en held continuously high: legal; the block runs at clk rate.
- Reset (asynchronous, at any time including mid-line):
  - h_cnt = v_cnt = 0.
  - vga_hs = vga_vs = ~SYNC_POL.
  - vga_de = 0, vga_rgb = 0, pos_x = pos_y = 0, frame_start = 0, underflow = 0.
  - After release, the first pix_en starts a fresh frame and raises frame_start.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port pattern_sel (1 bit).
  - When pattern_sel = 1, vga_rgb shows 8 vertical colour bars, each H_ACTIVE/8 wide. Order: white, yellow, cyan, green, magenta, red, blue, black, at full 8-bit intensity.
  - pix_ready is forced 0 and underflow never sets.
  - When pattern_sel = 0, behaviour is identical to the undefined case.
- Undefined: no pattern_sel port and no pattern logic.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL computation functions;
  - counter width constants;
  - the colour-bar RGB constant table.
- One sub-module, vga_axis_counter, instantiated twice (H and V).
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Inputs: step enable.
  - Outputs: count, active, in_sync, wrap.

Test Plan:
- pix_en every 5th clk, pix_valid = 1, pix_data = pixel index:
  - vga_hs low for 96 pix_en, starting at h_cnt = 656;
  - vga_de high for 640 pixels per line;
  - vga_rgb equals the FIFO sequence in order.
- Run a full frame: vga_vs low for lines 490-491; frame_start fires once per 420000 pix_en; pos_y wraps from 524 to 0.
- Drop pix_valid at pos (100, 10):
  - vga_rgb = 0 at that pixel and underflow = 1;
  - the next valid word appears at pixel 101;
  - underflow_clr returns the flag to 0, but it stays 1 if another underflow coincides with the clear.
- Assert rst_n low mid-line at h_cnt = 300:
  - outputs take reset values immediately;
  - after release, the first pix_en produces frame_start and pos (0, 0).
- pix_valid = 1 during blanking: pix_ready stays 0 and no words are popped (count pops = 307200 per frame).
- With VGA_TEST_PATTERN_EN and pattern_sel = 1: pixel 0 = 0xFFFFFF, pixel 80 = 0xFFFF00, pixel 639 = 0x000000, pix_ready = 0 throughout.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants and colour-bar table
// for the VGA pixel-timing engine.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_DATA_W   = 24;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int axis_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total_default();
    return axis_total(DEF_H_ACTIVE, DEF_H_FP,
                      DEF_H_SYNC, DEF_H_BP);
  endfunction

  function automatic int v_total_default();
    return axis_total(DEF_V_ACTIVE, DEF_V_FP,
                      DEF_V_SYNC, DEF_V_BP);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (line or frame) with
// active/sync region decode and wrap strobe.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         active,
  output logic         in_sync,
  output logic         wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  assign wrap    = step && (count == LAST);
  assign active  = count < ACT_END;
  assign in_sync = (count >= SYNC_LO) && (count < SYNC_HI);

  // position counter, advances one unit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (step) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing engine driving hs/vs/de/rgb.
// Optional colour-bar source enabled by VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   DATA_W   = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic [DATA_W-1:0]  pix_data,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               underflow_clr,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [DATA_W-1:0]  vga_rgb,
  output logic [H_CNT_W-1:0] pos_x,
  output logic [V_CNT_W-1:0] pos_y,
  output logic               frame_start,
  output logic               underflow
);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic h_act, h_sync, h_wrap;
  logic v_act, v_sync, v_wrap;
  logic active;
  logic at_origin;
  logic uf_set;
  logic [DATA_W-1:0] rgb_next;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (H_CNT_W)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (pix_en),
    .count   (h_cnt),
    .active  (h_act),
    .in_sync (h_sync),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (V_CNT_W)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (h_wrap),
    .count   (v_cnt),
    .active  (v_act),
    .in_sync (v_sync),
    .wrap    (v_wrap)
  );

  assign active = h_act && v_act;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;

  assign bar_idx   = 3'(int'(h_cnt) / BAR_W);
  assign pix_ready = pix_en && active && !pattern_sel;
`else
  assign pix_ready = pix_en && active;
`endif

  // pixel source select and underflow detect
  always_comb begin
    rgb_next = '0;
    uf_set   = 1'b0;
    if (active) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel) begin
        rgb_next = DATA_W'(BAR_RGB[bar_idx]);
      end else begin
`endif
        if (pix_valid) begin
          rgb_next = pix_data;
        end else begin
          uf_set = pix_en;
        end
`ifdef VGA_TEST_PATTERN_EN
      end
`endif
    end
  end

  // counters sit at (0,0) after reset or a frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_origin <= 1'b1;
    end else if (v_wrap) begin
      at_origin <= 1'b1;
    end else if (pix_en) begin
      at_origin <= 1'b0;
    end
  end

  // video output registers, loaded once per pixel strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && at_origin;
      if (pix_en) begin
        vga_hs  <= h_sync ? SYNC_POL : ~SYNC_POL;
        vga_vs  <= v_sync ? SYNC_POL : ~SYNC_POL;
        vga_de  <= active;
        vga_rgb <= rgb_next;
        pos_x   <= h_cnt;
        pos_y   <= v_cnt;
      end
    end
  end

  // sticky underflow; a new event beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (uf_set) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench with an arithmetic
// position model for vga_timing_gen (reduced timing).
module tb_vga_timing_gen;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int VA = 20;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        underflow_clr = 1'b0;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [23:0] vga_rgb;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        frame_start;
  logic        underflow;
  logic        pat;

`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
  assign pat = pattern_sel;
`else
  assign pat = 1'b0;
`endif

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .DATA_W (24)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_en        (pix_en),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .underflow_clr (underflow_clr),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel   (pattern_sel),
`endif
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_de        (vga_de),
    .vga_rgb       (vga_rgb),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] word(input int k);
    return 24'(k * 40503 + 17);
  endfunction

  function automatic int hx(input int k);
    return k % HT;
  endfunction

  function automatic int vy(input int k);
    return (k / HT) % VT;
  endfunction

  function automatic bit act_at(input int k);
    return (hx(k) < HA) && (vy(k) < VA);
  endfunction

  function automatic bit in_win(input int p, input int lo, input int w);
    return (p >= lo) && (p < lo + w);
  endfunction

  function automatic logic [23:0] bar(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // reference model: n = pixel strobes since reset
  int          n = 0;
  int          m_pops = 0;
  logic        e_hs, e_vs, e_de, e_fs, e_uf;
  logic [10:0] e_x;
  logic [9:0]  e_y;
  logic [23:0] e_rgb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     <= 0;
      e_hs  <= 1'b1;
      e_vs  <= 1'b1;
      e_de  <= 1'b0;
      e_fs  <= 1'b0;
      e_uf  <= 1'b0;
      e_x   <= '0;
      e_y   <= '0;
      e_rgb <= '0;
    end else begin
      e_fs <= 1'b0;
      if (underflow_clr) e_uf <= 1'b0;
      if (pix_en) begin
        n     <= n + 1;
        e_x   <= 11'(hx(n));
        e_y   <= 10'(vy(n));
        e_de  <= act_at(n);
        e_hs  <= !in_win(hx(n), HA + HF, HS);
        e_vs  <= !in_win(vy(n), VA + VF, VS);
        e_fs  <= (n % FRAME) == 0;
        e_rgb <= '0;
        if (act_at(n)) begin
          if (pat) begin
            e_rgb <= bar(hx(n) / (HA / 8));
          end else if (pix_valid) begin
            e_rgb  <= word(m_pops);
            m_pops <= m_pops + 1;
          end else begin
            e_uf <= 1'b1;
          end
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int f_pops = 0;
  int fs_seen = 0;

  task automatic lit(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // one clock: drive, compare at negedge, advance FIFO
  task automatic tick(input bit en, input bit vld, input bit clr);
    logic [50:0] got;
    logic [50:0] want;
    bit          rdy;
    bit          pop;
    pix_en        = en;
    pix_valid     = vld;
    underflow_clr = clr;
    pix_data      = vld ? word(f_pops) : 24'($urandom);
    @(negedge clk);
    rdy  = pix_en && act_at(n) && !pat && rst_n;
    got  = {vga_hs, vga_vs, vga_de, frame_start, underflow,
            pix_ready, pos_x, pos_y, vga_rgb};
    want = {e_hs, e_vs, e_de, e_fs, e_uf,
            rdy, e_x, e_y, e_rgb};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL cycle n=%0d got=%h want=%h", n, got, want);
    end
    if (frame_start === 1'b1) fs_seen++;
    pop = pix_ready && pix_valid;
    @(posedge clk);
    #1;
    if (pop && rst_n) f_pops++;
  endtask

  task automatic run_to(input int target, input bit vld);
    int g = 0;
    while (n < target && g < 60000) begin
      tick(1'b1, vld, 1'b0);
      g++;
    end
    lit("run_to_bound", n, target);
  endtask

  task automatic run5_to(input int target);
    int g = 0;
    while (n < target && g < 20000) begin
      repeat (4) tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      g++;
    end
    lit("run5_bound", n, target);
  endtask

  task automatic reset_vals(input string tag);
    lit({tag, "_hs"}, int'(vga_hs), 1);
    lit({tag, "_vs"}, int'(vga_vs), 1);
    lit({tag, "_de"}, int'(vga_de), 0);
    lit({tag, "_rgb"}, int'(vga_rgb), 0);
    lit({tag, "_x"}, int'(pos_x), 0);
    lit({tag, "_y"}, int'(pos_y), 0);
    lit({tag, "_fs"}, int'(frame_start), 0);
    lit({tag, "_uf"}, int'(underflow), 0);
  endtask

  initial begin
    int p0;
    int w;
    int g;

    repeat (3) tick(1'b0, 1'b1, 1'b0);
    reset_vals("rst");
    rst_n = 1'b1;
    p0 = f_pops;

    run5_to(1);
    lit("first_fs", int'(frame_start), 1);
    lit("first_x", int'(pos_x), 0);
    lit("first_y", int'(pos_y), 0);
    lit("first_de", int'(vga_de), 1);
    lit("first_rgb", int'(vga_rgb), int'(word(p0)));
    tick(1'b0, 1'b1, 1'b0);
    lit("fs_pulse_end", int'(frame_start), 0);
    lit("hold_x", int'(pos_x), 0);

    run5_to(64);
    lit("last_act_de", int'(vga_de), 1);
    lit("last_act_x", int'(pos_x), 63);
    run5_to(65);
    lit("fp_de", int'(vga_de), 0);
    lit("fp_rgb", int'(vga_rgb), 0);
    run5_to(68);
    lit("pre_hs", int'(vga_hs), 1);
    run5_to(69);
    lit("hs_start", int'(vga_hs), 0);
    lit("hs_start_x", int'(pos_x), 68);
    run5_to(76);
    lit("hs_last", int'(vga_hs), 0);
    run5_to(77);
    lit("hs_end", int'(vga_hs), 1);
    lit("hs_end_x", int'(pos_x), 76);

    run5_to(22 * HT + 1);
    lit("vs_start", int'(vga_vs), 0);
    lit("vs_start_y", int'(pos_y), 22);
    run5_to(24 * HT + 1);
    lit("vs_end", int'(vga_vs), 1);
    run5_to(FRAME);
    lit("last_y", int'(pos_y), VT - 1);
    lit("last_x", int'(pos_x), HT - 1);
    lit("pops_frame", f_pops - p0, HA * VA);
    lit("fs_per_frame", fs_seen, 1);
    run5_to(FRAME + 1);
    lit("wrap_fs", int'(frame_start), 1);
    lit("wrap_y", int'(pos_y), 0);
    lit("wrap_x", int'(pos_x), 0);

    run_to(FRAME + 3 * HT + 10, 1'b1);
    w = f_pops;
    tick(1'b1, 1'b0, 1'b0);
    lit("uf_set", int'(underflow), 1);
    lit("uf_rgb", int'(vga_rgb), 0);
    lit("uf_x", int'(pos_x), 10);
    lit("uf_y", int'(pos_y), 3);
    lit("uf_nopop", f_pops, w);
    tick(1'b1, 1'b1, 1'b0);
    lit("uf_next_x", int'(pos_x), 11);
    lit("uf_next_rgb", int'(vga_rgb), int'(word(w)));
    lit("uf_sticky", int'(underflow), 1);
    tick(1'b0, 1'b1, 1'b1);
    lit("uf_clr", int'(underflow), 0);
    tick(1'b1, 1'b0, 1'b1);
    lit("uf_set_wins", int'(underflow), 1);
    tick(1'b0, 1'b1, 1'b1);
    lit("uf_clr2", int'(underflow), 0);
    run_to(FRAME + 3 * HT + 70, 1'b1);
    repeat (5) tick(1'b1, 1'b0, 1'b0);
    lit("blank_no_uf", int'(underflow), 0);

    repeat (20000) begin
      tick(1'($urandom % 3 != 0), 1'($urandom % 16 != 0),
           1'($urandom % 32 == 0));
    end
    repeat (600) tick(1'b1, 1'($urandom % 8 != 0), 1'b0);

    g = 0;
    while (!(hx(n) == 29 && vy(n) < VA) && g < 5000) begin
      tick(1'b1, 1'b1, 1'b0);
      g++;
    end
    tick(1'b1, 1'b0, 1'b0);
    lit("mid_uf", int'(underflow), 1);
    lit("mid_x", int'(pos_x), 29);
    pix_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("async");
    @(posedge clk);
    #1;
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    lit("rel_fs", int'(frame_start), 1);
    lit("rel_x", int'(pos_x), 0);
    lit("rel_y", int'(pos_y), 0);
    lit("rel_de", int'(vga_de), 1);
    tick(1'b0, 1'b1, 1'b0);
    lit("rel_fs_end", int'(frame_start), 0);

`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    run_to(HT + 1, 1'b1);
    lit("bar_white", int'(vga_rgb), 32'hFFFFFF);
    run_to(HT + 9, 1'b1);
    lit("bar_yellow", int'(vga_rgb), 32'hFFFF00);
    run_to(HT + 64, 1'b0);
    lit("bar_black", int'(vga_rgb), 0);
    lit("bar_no_uf", int'(underflow), 0);
    pattern_sel = 1'b0;
    repeat (4) tick(1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
